// File: rtl/pla_sweep_controller.sv
// Sweeps input vectors over two PLA netlists sharing one input bus, counts ones
// and mismatches, and streams mismatching vectors out over a valid/ready port.
module pla_sweep_controller #(
  parameter int NI     = 21,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [NI-1:0]    base,
  input  logic [CNT_W-1:0] count,
  output logic [NI-1:0]    x_out,
  input  logic             y_a,
  input  logic             y_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] mism_cnt,
  output logic             first_mism_vld,
  output logic [NI-1:0]    first_mism_vec,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [NI-1:0]    ev_vec
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0]       TIMER_INIT = 4'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [NI-1:0]    x_q, x_d;
  logic [3:0]       timer_q, timer_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] mism_q, mism_d;
  logic             fmv_q, fmv_d;
  logic [NI-1:0]    fmvec_q, fmvec_d;
  logic             evv_q, evv_d;
  logic [NI-1:0]    evvec_q, evvec_d;

  logic slot_free;
  logic commit;
  logic mismatch;
  logic launch;
  logic last_vec;

  // A sample only commits when its possible mismatch event has somewhere to go.
  assign slot_free = !evv_q || ev_ready;
  assign commit    = (state_q == ST_SAMPLE) && !abort && slot_free;
  assign mismatch  = y_a ^ y_b;
  assign launch    = (state_q == ST_IDLE) && start;
  assign last_vec  = (rem_q == CNT_ONE);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (count == '0) ? ST_DONE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (timer_q == 4'd0) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (slot_free) begin
          state_d = last_vec ? ST_DONE : ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // Datapath next values
  always_comb begin
    x_d     = x_q;
    timer_d = timer_q;
    rem_d   = rem_q;
    ones_d  = ones_q;
    mism_d  = mism_q;
    fmv_d   = fmv_q;
    fmvec_d = fmvec_q;
    evv_d   = evv_q;
    evvec_d = evvec_q;

    // Consumer handshake retires the pending event; a same-cycle load overrides below.
    if (evv_q && ev_ready) begin
      evv_d = 1'b0;
    end

    if (launch) begin
      ones_d = '0;
      mism_d = '0;
      if (count != '0) begin
        x_d     = base;
        rem_d   = count;
        timer_d = TIMER_INIT;
        fmv_d   = 1'b0;
        evv_d   = 1'b0;
      end
    end

    if (state_q == ST_SETTLE && !abort && timer_q != 4'd0) begin
      timer_d = timer_q - 4'd1;
    end

    if (commit) begin
      if (y_a) begin
        ones_d = sat_inc(ones_q);
      end
      if (mismatch) begin
        mism_d  = sat_inc(mism_q);
        evv_d   = 1'b1;
        evvec_d = x_q;
        if (!fmv_q) begin
          fmv_d   = 1'b1;
          fmvec_d = x_q;
        end
      end
      rem_d = rem_q - CNT_ONE;
      if (!last_vec) begin
        x_d     = x_q + 1'b1;
        timer_d = TIMER_INIT;
      end
    end

    // Abort leaves x_out and the counters where they are but drops the event.
    if (abort && state_q != ST_IDLE) begin
      evv_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      timer_q <= '0;
      rem_q   <= '0;
      ones_q  <= '0;
      mism_q  <= '0;
      fmv_q   <= 1'b0;
      fmvec_q <= '0;
      evv_q   <= 1'b0;
      evvec_q <= '0;
    end else begin
      x_q     <= x_d;
      timer_q <= timer_d;
      rem_q   <= rem_d;
      ones_q  <= ones_d;
      mism_q  <= mism_d;
      fmv_q   <= fmv_d;
      fmvec_q <= fmvec_d;
      evv_q   <= evv_d;
      evvec_q <= evvec_d;
    end
  end

  assign x_out          = x_q;
  assign ones_cnt       = ones_q;
  assign mism_cnt       = mism_q;
  assign first_mism_vld = fmv_q;
  assign first_mism_vec = fmvec_q;
  assign ev_valid       = evv_q;
  assign ev_vec         = evvec_q;

endmodule

// File: tb/tb_pla_sweep_controller.sv
// Directed bench for pla_sweep_controller: a toy netlist pair (y_a = x[0], y_b = y_a
// with an optional injected difference at x==5) driven through the sweep scenarios.
module tb_pla_sweep_controller;

  localparam int NI     = 21;
  localparam int SETTLE = 2;
  localparam int CNT_W  = 22;
  localparam int PER    = SETTLE + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [NI-1:0]    base;
  logic [CNT_W-1:0] count;
  logic [NI-1:0]    x_out;
  logic             y_a;
  logic             y_b;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] ones_cnt;
  logic [CNT_W-1:0] mism_cnt;
  logic             first_mism_vld;
  logic [NI-1:0]    first_mism_vec;
  logic             ev_valid;
  logic             ev_ready;
  logic [NI-1:0]    ev_vec;
  logic             mism_en;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign y_a = x_out[0];
  assign y_b = y_a ^ (mism_en && (x_out == 21'd5));

  pla_sweep_controller #(.NI(NI), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .base           (base),
    .count          (count),
    .x_out          (x_out),
    .y_a            (y_a),
    .y_b            (y_b),
    .busy           (busy),
    .done           (done),
    .ones_cnt       (ones_cnt),
    .mism_cnt       (mism_cnt),
    .first_mism_vld (first_mism_vld),
    .first_mism_vec (first_mism_vec),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_vec         (ev_vec)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_x(input logic [NI-1:0] v);
    int n = 0;
    while (x_out !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_x_timeout", 32'(x_out), 32'(v));
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done_timeout", 32'(done), 32'd1);
  endtask

  // Unstalled sweep: x_out must step once every PER cycles and done must land exactly
  // n*PER cycles after the start edge. rk>=0 re-pulses start with another base.
  task automatic sweep(input logic [NI-1:0] b, input logic [CNT_W-1:0] n,
                       input int rk, input logic [31:0] exp_ones);
    logic [NI-1:0] ex;
    @(negedge clk);
    base  = b;
    count = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < int'(n) * PER; k++) begin
      ex = b + NI'(k / PER);
      chk("x_step", 32'(x_out), 32'(ex));
      chk("done_early", 32'(done), 32'd0);
      chk("busy_mid", 32'(busy), 32'd1);
      if (k == rk) begin
        base  = b + 21'd100;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("ones_cnt", 32'(ones_cnt), exp_ones);
    chk("mism_cnt", 32'(mism_cnt), 32'd0);
    $display("sweep base=%0h count=%0d ones=%0d mism=%0d", b, n, ones_cnt, mism_cnt);
  endtask

  initial begin
    int dones;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    base     = '0;
    count    = '0;
    ev_ready = 1'b0;
    mism_en  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_x_out", 32'(x_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ev_valid", 32'(ev_valid), 32'd0);
    chk("rst_ones", 32'(ones_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset released");

    // Basic sweep 0..3
    sweep(21'd0, 22'd4, -1, 32'd2);

    // count=0: done the cycle after start, counters cleared
    @(negedge clk);
    base  = 21'h55;
    count = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cnt0_done", 32'(done), 32'd1);
    chk("cnt0_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("cnt0_done_off", 32'(done), 32'd0);
    chk("cnt0_busy_off", 32'(busy), 32'd0);
    chk("cnt0_ones", 32'(ones_cnt), 32'd0);
    chk("cnt0_mism", 32'(mism_cnt), 32'd0);
    $display("count=0 sweep ones=%0d mism=%0d", ones_cnt, mism_cnt);

    // Wrap past the top of the input space
    sweep(21'h1FFFFE, 22'd4, -1, 32'd2);

    // Restart while busy is ignored
    sweep(21'd8, 22'd4, 4, 32'd2);

    // Mismatch at x=5 with a back-pressured consumer
    mism_en  = 1'b1;
    ev_ready = 1'b0;
    @(negedge clk);
    base  = 21'd0;
    count = 22'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_x(21'd6);
    chk("ev_valid_set", 32'(ev_valid), 32'd1);
    chk("ev_vec", 32'(ev_vec), 32'd5);
    chk("first_vld", 32'(first_mism_vld), 32'd1);
    chk("first_vec", 32'(first_mism_vec), 32'd5);
    chk("mism_one", 32'(mism_cnt), 32'd1);
    repeat (10) @(negedge clk);
    chk("stall_x", 32'(x_out), 32'd6);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_ev_vec", 32'(ev_vec), 32'd5);
    chk("stall_ones", 32'(ones_cnt), 32'd3);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    chk("release_ev_valid", 32'(ev_valid), 32'd0);
    chk("release_x", 32'(x_out), 32'd7);
    wait_done();
    @(negedge clk);
    chk("mism_final", 32'(mism_cnt), 32'd1);
    chk("ones_final", 32'(ones_cnt), 32'd4);
    chk("first_vec_hold", 32'(first_mism_vec), 32'd5);
    $display("mismatch sweep ones=%0d mism=%0d first=%0h", ones_cnt, mism_cnt, first_mism_vec);
    mism_en = 1'b0;

    // Abort at vector 3 of 8
    @(negedge clk);
    base  = 21'd0;
    count = 22'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_x(21'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_x_hold", 32'(x_out), 32'd3);
    chk("abort_ev_valid", 32'(ev_valid), 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_ones_frozen", 32'(ones_cnt), 32'd1);
    $display("abort at x=3 ones=%0d dones=%0d", ones_cnt, dones);

    // Asynchronous reset mid-sweep
    base  = 21'd0;
    count = 22'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_x(21'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_x_out", 32'(x_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ones", 32'(ones_cnt), 32'd0);
    chk("arst_first_vld", 32'(first_mism_vld), 32'd0);
    $display("async reset mid-sweep x=%0h busy=%0d", x_out, busy);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
